// File: rtl/stack_node_pkg.sv
// stack_node_pkg: shared direction indices, word width, stack depth and a priority helper
package stack_node_pkg;
    localparam int DIR_LEFT    = 0;
    localparam int DIR_RIGHT   = 1;
    localparam int DIR_UP      = 2;
    localparam int DIR_DOWN    = 3;
    localparam int NUM_DIRS    = 4;
    localparam int DATA_WIDTH  = 11;
    localparam int STACK_DEPTH = 15;
    typedef logic [NUM_DIRS-1:0] dir_vec_t;
    function automatic dir_vec_t first_one(input dir_vec_t v);
        return v & (~v + dir_vec_t'(1));
    endfunction
endpackage

// File: rtl/stack_node_lifo_mem.sv
// lifo_mem: DEPTH x DATA_WIDTH register array, one write port and an asynchronous read port
module lifo_mem
    import stack_node_pkg::*;
#(
    parameter int DEPTH      = STACK_DEPTH,
    parameter int DATA_WIDTH = stack_node_pkg::DATA_WIDTH,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end
    assign rdata = mem_q[raddr];
endmodule

// File: rtl/stack_node.sv
// stack_node: four-port LIFO memory node; fixed-priority push/pop arbitration, one op per cycle
module stack_node
    import stack_node_pkg::*;
#(
    parameter int DEPTH      = STACK_DEPTH,
    parameter int DATA_WIDTH = stack_node_pkg::DATA_WIDTH,
    parameter int CW         = $clog2(DEPTH+1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] left_in_data,
    input  logic [DATA_WIDTH-1:0] right_in_data,
    input  logic [DATA_WIDTH-1:0] up_in_data,
    input  logic [DATA_WIDTH-1:0] down_in_data,
    input  logic                  left_in_valid,
    input  logic                  right_in_valid,
    input  logic                  up_in_valid,
    input  logic                  down_in_valid,
    output logic                  left_in_ready,
    output logic                  right_in_ready,
    output logic                  up_in_ready,
    output logic                  down_in_ready,
    output logic [DATA_WIDTH-1:0] left_out_data,
    output logic [DATA_WIDTH-1:0] right_out_data,
    output logic [DATA_WIDTH-1:0] up_out_data,
    output logic [DATA_WIDTH-1:0] down_out_data,
    output logic                  left_out_valid,
    output logic                  right_out_valid,
    output logic                  up_out_valid,
    output logic                  down_out_valid,
    input  logic                  left_out_ready,
    input  logic                  right_out_ready,
    input  logic                  up_out_ready,
    input  logic                  down_out_ready,
    output logic [CW-1:0]         count
);
    localparam int AW = $clog2(DEPTH);
    dir_vec_t in_valid, in_ready, out_ready, out_valid, grant_q, grant_d;
    logic [DATA_WIDTH-1:0] in_data [NUM_DIRS];
    logic [DATA_WIDTH-1:0] push_data, top;
    logic [CW-1:0] count_q, count_d;
    logic push, pop;
    assign in_valid  = {down_in_valid, up_in_valid, right_in_valid, left_in_valid};
    assign out_ready = {down_out_ready, up_out_ready, right_out_ready, left_out_ready};
    assign in_data[DIR_LEFT]  = left_in_data;
    assign in_data[DIR_RIGHT] = right_in_data;
    assign in_data[DIR_UP]    = up_in_data;
    assign in_data[DIR_DOWN]  = down_in_data;
    assign {down_in_ready, up_in_ready, right_in_ready, left_in_ready}     = in_ready;
    assign {down_out_valid, up_out_valid, right_out_valid, left_out_valid} = out_valid;
    always_comb begin
        // pushes are blocked while an offer is outstanding so a pop never races a push
        in_ready  = (!reset && grant_q == '0 && count_q < CW'(DEPTH)) ? first_one(in_valid) : '0;
        push      = |in_ready;
        pop       = |(grant_q & out_ready);
        push_data = '0;
        for (int s = 0; s < NUM_DIRS; s++) push_data = in_ready[s] ? in_data[s] : push_data;
        // an offer lasts exactly one cycle: it either completes or is withdrawn
        grant_d   = grant_q != '0 ? '0 : count_q != '0 ? first_one(out_ready) : '0;
        count_d   = push ? count_q + CW'(1) : pop ? count_q - CW'(1) : count_q;
        out_valid = reset ? '0 : grant_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            grant_q <= '0;
        end else begin
            count_q <= count_d;
            grant_q <= grant_d;
        end
    end
    lifo_mem #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (AW'(count_q)),
        .wdata (push_data),
        .raddr (AW'(count_q - CW'(1))),
        .rdata (top)
    );
    assign left_out_data  = (reset || count_q == '0) ? '0 : top;
    assign right_out_data = left_out_data;
    assign up_out_data    = left_out_data;
    assign down_out_data  = left_out_data;
    assign count          = count_q;
endmodule

// File: tb/tb_stack_node.sv
// tb_stack_node: table vectors, directed corner sequences and random traffic against a queue model
module tb_stack_node;
    logic clk = 0;
    logic rst;
    logic [3:0] iv, ordy;
    logic [10:0] id [4];
    wire  [3:0] rdy, ov;
    wire  [10:0] od0, od1, od2, od3;
    wire  [3:0] cnt;
    int checks = 0;
    int errors = 0;
    logic [10:0] q [$];
    int mg;

    always #5 clk = ~clk;

    stack_node dut (
        .clk(clk), .reset(rst),
        .left_in_data(id[0]), .right_in_data(id[1]), .up_in_data(id[2]), .down_in_data(id[3]),
        .left_in_valid(iv[0]), .right_in_valid(iv[1]), .up_in_valid(iv[2]), .down_in_valid(iv[3]),
        .left_in_ready(rdy[0]), .right_in_ready(rdy[1]), .up_in_ready(rdy[2]), .down_in_ready(rdy[3]),
        .left_out_data(od0), .right_out_data(od1), .up_out_data(od2), .down_out_data(od3),
        .left_out_valid(ov[0]), .right_out_valid(ov[1]), .up_out_valid(ov[2]), .down_out_valid(ov[3]),
        .left_out_ready(ordy[0]), .right_out_ready(ordy[1]), .up_out_ready(ordy[2]), .down_out_ready(ordy[3]),
        .count(cnt)
    );

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, a, e);
        end
    endtask

    // compare outputs with the model for the current cycle, then advance one clock
    task automatic step();
        logic [3:0] er, ev;
        logic [10:0] ed;
        bit found;
        #1;
        er = 0;
        found = 0;
        if (!rst && mg < 0 && q.size() < 15)
            for (int s = 0; s < 4; s++) if (iv[s] && !found) begin er[s] = 1; found = 1; end
        ev = (!rst && mg >= 0) ? 4'(1 << mg) : 4'b0;
        ed = (rst || q.size() == 0) ? 11'd0 : q[q.size()-1];
        chk("model_ready", 64'(rdy), 64'(er));
        chk("model_valid", 64'(ov), 64'(ev));
        chk("model_data", 64'({od3, od2, od1, od0}), 64'({4{ed}}));
        chk("model_count", 64'(cnt), 64'(q.size()));
        @(posedge clk);
        if (rst) begin
            q.delete();
            mg = -1;
        end else begin
            if (mg >= 0) begin
                if (ordy[mg]) void'(q.pop_back());
                mg = -1;
            end else if (q.size() != 0) begin
                for (int s = 0; s < 4; s++) if (ordy[s] && mg < 0) mg = s;
            end
            for (int s = 0; s < 4; s++) if (er[s]) q.push_back(id[s]);
        end
        @(negedge clk);
    endtask

    task automatic set_all(input logic [10:0] d);
        for (int s = 0; s < 4; s++) id[s] = d;
    endtask

    task automatic do_reset();
        rst = 1; iv = 0; ordy = 0;
        step();
        rst = 0;
    endtask

    task automatic push_one(input int side, input logic [10:0] d);
        iv = 4'(1 << side);
        id[side] = d;
        step();
        iv = 0;
    endtask

    typedef struct {
        logic r;
        logic [3:0] iv;
        logic [10:0] d;
        logic [3:0] ordy;
        int ec;
        logic [3:0] ev;
        logic [10:0] ed;
    } vec_t;
    vec_t tbl [11];

    initial begin
        mg = -1;
        rst = 1; iv = 0; ordy = 0;
        set_all(0);
        tbl[0]  = '{1'b1, 4'b0000, 11'd0,      4'b0000, 0, 4'b0000, 11'd0};
        tbl[1]  = '{1'b0, 4'b0001, 11'd5,      4'b0000, 1, 4'b0000, 11'd5};
        tbl[2]  = '{1'b0, 4'b0001, 11'd7,      4'b0000, 2, 4'b0000, 11'd7};
        tbl[3]  = '{1'b0, 4'b0001, 11'h7F7,    4'b0000, 3, 4'b0000, 11'h7F7};
        tbl[4]  = '{1'b0, 4'b0000, 11'd0,      4'b0100, 3, 4'b0100, 11'h7F7};
        tbl[5]  = '{1'b0, 4'b0000, 11'd0,      4'b0100, 2, 4'b0000, 11'd7};
        tbl[6]  = '{1'b0, 4'b0000, 11'd0,      4'b0100, 2, 4'b0100, 11'd7};
        tbl[7]  = '{1'b0, 4'b0000, 11'd0,      4'b0100, 1, 4'b0000, 11'd5};
        tbl[8]  = '{1'b0, 4'b0000, 11'd0,      4'b0100, 1, 4'b0100, 11'd5};
        tbl[9]  = '{1'b0, 4'b0000, 11'd0,      4'b0100, 0, 4'b0000, 11'd0};
        tbl[10] = '{1'b0, 4'b0000, 11'd0,      4'b0100, 0, 4'b0000, 11'd0};
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            rst = tbl[i].r; iv = tbl[i].iv; ordy = tbl[i].ordy;
            set_all(tbl[i].d);
            step();
            #1;
            chk($sformatf("tbl%0d_count", i), 64'(cnt), 64'(tbl[i].ec));
            chk($sformatf("tbl%0d_valid", i), 64'(ov), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d_data", i), 64'(od2), 64'(tbl[i].ed));
        end
        ordy = 0;

        do_reset();
        for (int i = 1; i <= 15; i++) push_one(1, 11'(i));
        iv = 4'b0010; id[1] = 11'd16;
        #1;
        chk("full_count", 64'(cnt), 64'd15);
        chk("full_ready", 64'(rdy[1]), 64'd0);
        step();
        iv = 0; ordy = 4'b1000;
        step();
        chk("full_pop_valid", 64'(ov), 64'b1000);
        chk("full_pop_data", 64'(od3), 64'd15);
        step();
        ordy = 0; iv = 4'b0010; id[1] = 11'd99;
        #1;
        chk("full_ready_again", 64'(rdy[1]), 64'd1);
        step();
        iv = 0;

        do_reset();
        iv = 4'b1101; id[0] = 11'd1; id[2] = 11'd3; id[3] = 11'd4;
        #1;
        chk("prio_push1", 64'(rdy), 64'b0001);
        step();
        iv[0] = 0;
        #1;
        chk("prio_push2", 64'(rdy), 64'b0100);
        step();
        iv[2] = 0;
        #1;
        chk("prio_push3", 64'(rdy), 64'b1000);
        step();
        iv = 0;
        chk("prio_count", 64'(cnt), 64'd3);
        chk("prio_top", 64'(od0), 64'd4);

        do_reset();
        push_one(0, 11'd10);
        push_one(0, 11'd20);
        ordy = 4'b1010;
        step();
        chk("popprio_valid", 64'(ov), 64'b0010);
        chk("popprio_data", 64'(od1), 64'd20);
        step();
        ordy = 4'b1000;
        step();
        chk("withdraw_offer", 64'(ov), 64'b1000);
        ordy = 0;
        step();
        chk("withdraw_valid", 64'(ov), 64'b0000);
        chk("withdraw_count", 64'(cnt), 64'd1);
        chk("withdraw_top", 64'(od3), 64'd10);

        do_reset();
        ordy = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("empty_no_valid", 64'(ov), 64'd0);
        end
        iv = 4'b0001; id[0] = 11'h7FF;
        step();
        iv = 0;
        chk("empty_push_count", 64'(cnt), 64'd1);
        step();
        chk("empty_offer_valid", 64'(ov), 64'b0100);
        chk("empty_offer_data", 64'(od2), 64'h7FF);
        iv = 4'b0001; id[0] = 11'd55;
        #1;
        chk("offer_blocks_push", 64'(rdy[0]), 64'd0);
        rst = 1;
        step();
        rst = 0; iv = 0; ordy = 0;
        chk("reset_valid", 64'(ov), 64'd0);
        chk("reset_count", 64'(cnt), 64'd0);
        chk("reset_data", 64'(od0), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            bit push_phase;
            push_phase = ((i / 150) % 2) == 0;
            rst  = ($urandom_range(0, 127) == 0);
            iv   = (push_phase || $urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            ordy = (!push_phase || $urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            for (int s = 0; s < 4; s++) id[s] = 11'($urandom_range(0, 2047));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stack_node.md
# stack_node

Memory node for the TIS-100 grid: a LIFO of signed 11-bit words attached to neighbouring compute nodes through the same four directional valid/ready ports that each compute node's `dir_manager` drives. It consumes values that neighbours write toward it and produces values that neighbours read from it. Arbitration among the four neighbours is fixed-priority, and each cycle performs at most one stack operation.

## Interface
- `DEPTH`, 15: stack capacity in words.
- `DATA_WIDTH`, 11: word width, two's complement.
- `clk` input 1: single clock. All state changes on its rising edge.
- `reset` input 1: synchronous, active-high.
- `left_in_data`, `right_in_data`, `up_in_data`, `down_in_data` input 11 (signed): words pushed by the neighbour on that side.
- `left_in_valid`, `right_in_valid`, `up_in_valid`, `down_in_valid` input 1: the neighbour on that side is offering a push.
- `left_in_ready`, `right_in_ready`, `up_in_ready`, `down_in_ready` output 1: the push on that side is accepted this cycle.
- `left_out_data`, `right_out_data`, `up_out_data`, `down_out_data` output 11 (signed): top of stack.
- `left_out_valid`, `right_out_valid`, `up_out_valid`, `down_out_valid` output 1: a pop is offered to that side.
- `left_out_ready`, `right_out_ready`, `up_out_ready`, `down_out_ready` input 1: the neighbour on that side wants to read.
- `count` output 4: current occupancy, range 0..DEPTH.

## Operation
- **Transfer rule.** A transfer happens on a port only when its valid and ready are both high at the rising edge.
- **Priority.** Side priority is left > right > up > down, for both push and pop arbitration.
- **Grant register.** `grant` (one-hot over 4 sides, or none) holds the side currently offered a pop.
  - Registered. Its value is `out_valid`, per side.
- **Pop arbitration.** Arbitration happens only when `grant` is none and `count` != 0.
  - The next `grant` is the highest-priority side whose `out_ready` is high.
  - If no side has `out_ready` high, `grant` stays none.
- **Pop completion.** While `grant` = side S:
  - If `S_out_ready` is high, the pop completes: `count` decrements and `grant` clears.
  - If `S_out_ready` is low, `grant` clears with no pop, so the offer is withdrawn.
- **out_data.** All four `out_data` buses carry `mem[count-1]`. They carry 0 when `count` == 0.
- **Push acceptance.** `in_ready` is combinational. At most one side is ready, and only when all of the following hold:
  - `grant` is none;
  - `count` < DEPTH;
  - that side is the highest-priority side whose `in_valid` is high.
- **Push effect.** An accepted push writes `mem[count]` and increments `count`.
- **One operation per cycle.** A push never occurs in a cycle where `grant` is non-none. Pops therefore take precedence, and a completed pop is followed by a push-eligible cycle.
- **Arbitration vs push.** A cycle that sets `grant` (arbitration) may also accept a push. The pushed word becomes the top before the offer appears.
- **Boundary conditions.**
  - Empty: no arbitration and all `out_valid` low. Pushes are still accepted.
  - Full (`count` == DEPTH): all `in_ready` low. Pops are unaffected.
  - Data is stored unmodified; there is no saturation.
  - `count` never wraps.

## Timing
- **Reset (synchronous).** On a `reset` cycle:
  - `count` ← 0 and `grant` ← none.
  - All `out_valid` and `out_data` are 0.
  - All `in_ready` are forced 0 while `reset` is high.
  - Storage contents are don't-care.
- **Reset during an operation.** Reset asserted during an outstanding offer aborts it: no pop, and `count` becomes 0.
- **Pop latency.** Rising edge where `out_ready` is sampled → `out_valid` high one cycle later. The pop completes at the next edge if `out_ready` is held. Minimum 2 cycles per pop on one side.
- **Push latency.** Zero-latency acceptance. Back-to-back pushes are possible, one word per cycle.
- **Data visibility.** A pushed word is visible on `out_data` the cycle after acceptance.
- **Handshake stability.** `out_data` is stable for the entire cycle `out_valid` is high.

## Structure
- Add to the shared `my_params.vh` include:
  - `DIR_LEFT`=0, `DIR_RIGHT`=1, `DIR_UP`=2, `DIR_DOWN`=3, used as the priority index order;
  - `DATA_WIDTH`=11;
  - `STACK_DEPTH`=15.
- Sub-module `lifo_mem`: a DEPTH×DATA_WIDTH register array with a write port (`we`, `waddr`, `wdata`) and an asynchronous read port.
- The arbiter, `count`, and `grant` logic live in `stack_node`.
- `count` width is `$clog2(DEPTH+1)`.

## Test plan
- **Push then pop.** Push 5, 7, -9 on left over 3 cycles → `count` = 3. Then hold `up_out_ready` → `up_out_valid` pulses deliver -9, 7, 5, each 2 cycles apart; `count` ends at 0.
- **Full.** Push 15 words (1..15) on right → `count` = 15 and `right_in_ready` = 0 on the 16th. One pop on down returns 15, after which `right_in_ready` = 1 again.
- **Push priority.** left, up, and down `in_valid` all high with data 1, 3, 4 → order accepted is 1, 3, 4, one per cycle, and `count` = 3.
- **Pop priority and withdrawal.**
  - Stack holds [10, 20]; right and down `out_ready` both high → right receives 20.
  - Next, drop `down_out_ready` while it holds an offer → `down_out_valid` drops after one cycle; `count` stays 1 and top stays 10.
- **Empty and pop-vs-push.**
  - Empty stack with `up_out_ready` high → no `out_valid` for 10 cycles.
  - Then `left_in_valid` with data -1 → pushed; the next cycle `up_out_valid` is high with -1. While that offer is outstanding, `left_in_ready` = 0.
- **Reset mid-offer.** Reset during an outstanding offer → the next cycle all `out_valid` are 0, `count` = 0, and `out_data` = 0.
